// File: rtl/chirp_pkg.sv
// rtl/chirp_pkg.sv - shared state encoding, widths and demo constants for the chirp scheduler
package chirp_pkg;

    localparam int PINC_W_DEF  = 32;
    localparam int CNT_W_DEF   = 16;
    localparam int TDATA_W_DEF = 64;

    localparam logic [31:0] DEMO_START = 32'h0001_86A0;
    localparam logic [31:0] DEMO_STEP  = 32'h0001_86A0;
    localparam logic [15:0] DEMO_DWELL = 16'd100;
    localparam logic [15:0] DEMO_STEPS = 16'd25;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_DWELL = 3'd2,
        S_GAP   = 3'd3
    } state_e;

endpackage

// File: rtl/chirp_scheduler_if.sv
// rtl/chirp_scheduler_if.sv - phase-increment stream from the scheduler to the DDS compiler
interface chirp_scheduler_if #(
    parameter int TDATA_W = 64
) ();

    logic               tvalid;
    logic               tready;
    logic [TDATA_W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - loadable down-counter shared by the dwell and gap phases
module sched_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Loading N keeps the owning state alive for N+1 cycles; expiry is the cycle at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/chirp_scheduler.sv
// rtl/chirp_scheduler.sv - stepped-frequency chirp sequencer feeding the DDS phase-increment stream
module chirp_scheduler
    import chirp_pkg::*;
#(
    parameter int PINC_W  = PINC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TDATA_W = TDATA_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [PINC_W-1:0]  cfg_start_pinc,
    input  logic [PINC_W-1:0]  cfg_step_pinc,
    input  logic [CNT_W-1:0]   cfg_num_steps,
    input  logic [CNT_W-1:0]   cfg_dwell,
    input  logic [CNT_W-1:0]   cfg_num_chirps,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic               start,
    input  logic               abort,
    chirp_scheduler_if.master  m_axis_phase,
    output logic               busy,
    output logic               chirp_sync,
    output logic               done,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [PINC_W-1:0]  pinc_q, pinc_d;
    logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0]   chirp_cnt_q, chirp_cnt_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;

    logic [PINC_W-1:0]  start_q, step_q;
    logic [CNT_W-1:0]   steps_q, dwell_q, chirps_q, gap_q;

    logic               cfg_load, tmr_load, tmr_exp, hs;
    logic [CNT_W-1:0]   tmr_val, chirp_nxt;

    assign hs        = (state_q == S_SEND) && m_axis_phase.tready;
    assign chirp_nxt = chirp_cnt_q + ONE;

    sched_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    always_comb begin
        state_d     = state_q;
        pinc_d      = pinc_q;
        step_cnt_d  = step_cnt_q;
        chirp_cnt_d = chirp_cnt_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        cfg_load    = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort && (cfg_num_steps != '0)) begin
                    cfg_load    = 1'b1;
                    pinc_d      = cfg_start_pinc;
                    step_cnt_d  = '0;
                    chirp_cnt_d = '0;
                    abort_d     = 1'b0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                // An abort here must wait for the handshake so tvalid never drops unaccepted.
                if (abort) begin
                    abort_d = 1'b1;
                end
                if (hs) begin
                    if (abort_q || abort) begin
                        abort_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = (dwell_q == '0) ? '0 : dwell_q - ONE;
                        state_d  = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tmr_exp) begin
                    if (step_cnt_q != steps_q - ONE) begin
                        step_cnt_d = step_cnt_q + ONE;
                        pinc_d     = pinc_q + step_q;
                        state_d    = S_SEND;
                    end else begin
                        chirp_cnt_d = chirp_nxt;
                        if ((chirps_q != '0) && (chirp_nxt == chirps_q)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (gap_q != '0) begin
                            tmr_load = 1'b1;
                            tmr_val  = gap_q;
                            state_d  = S_GAP;
                        end else begin
                            pinc_d     = start_q;
                            step_cnt_d = '0;
                            state_d    = S_SEND;
                        end
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tmr_exp) begin
                    pinc_d     = start_q;
                    step_cnt_d = '0;
                    state_d    = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pinc_q      <= '0;
            step_cnt_q  <= '0;
            chirp_cnt_q <= '0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= '0;
            step_q      <= '0;
            steps_q     <= '0;
            dwell_q     <= '0;
            chirps_q    <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            pinc_q      <= pinc_d;
            step_cnt_q  <= step_cnt_d;
            chirp_cnt_q <= chirp_cnt_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            if (cfg_load) begin
                start_q  <= cfg_start_pinc;
                step_q   <= cfg_step_pinc;
                steps_q  <= cfg_num_steps;
                dwell_q  <= cfg_dwell;
                chirps_q <= cfg_num_chirps;
                gap_q    <= cfg_gap;
            end
        end
    end

    assign m_axis_phase.tvalid = (state_q == S_SEND);
    assign m_axis_phase.tdata  = {{(TDATA_W - PINC_W){1'b0}}, pinc_q};
    assign busy                = (state_q != S_IDLE);
    assign chirp_sync          = hs && (step_cnt_q == '0);
    assign done                = done_q;
    assign state               = state_q;

endmodule
